// File: rtl/adc_control_param.sv
// SAR ADC conversion sequencer: MSB steps decided in one cycle, trailing LSB steps majority-averaged.
// Define ADC_CTRL_SINGLE_SHOT_EN to add start_in and rest in IDLE between conversions.
module adc_control_param #(
    parameter int MATRIX_BITS   = 12,
    parameter int AVG_BITS      = 4,
    parameter int MAX_AVG_LOG2  = 5,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comparator_in,
    input  logic [2:0]             avg_control_in,
`ifdef ADC_CTRL_SINGLE_SHOT_EN
    input  logic                   start_in,
`endif
    output logic                   sample_out,
    output logic                   sample_out_n,
    output logic                   enable_loop_out,
    output logic                   conv_finished_strobe_out,
    output logic [MATRIX_BITS-1:0] pswitch_out,
    output logic [MATRIX_BITS-1:0] nswitch_out,
    output logic [MATRIX_BITS-1:0] result_out,
    output logic [2:0]             state_dbg_out
);

    localparam int BIT_W  = $clog2(MATRIX_BITS);
    localparam int CNT_W  = MAX_AVG_LOG2 + 1;
    localparam int SCNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

`ifdef ADC_CTRL_SINGLE_SHOT_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_AVERAGE = 3'd3,
        S_DONE    = 3'd4
    } state_t;
    localparam state_t RESET_STATE  = S_IDLE;
    localparam logic   RESET_SAMPLE = 1'b0;
`else
    typedef enum logic [2:0] {
        S_SAMPLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_AVERAGE = 3'd3,
        S_DONE    = 3'd4
    } state_t;
    localparam state_t RESET_STATE  = S_SAMPLE;
    localparam logic   RESET_SAMPLE = 1'b1;
`endif

    state_t                 r_state;
    logic                   r_sample;
    logic                   r_enable;
    logic                   r_strobe;
    logic [MATRIX_BITS-1:0] r_pswitch;
    logic [MATRIX_BITS-1:0] r_nswitch;
    logic [MATRIX_BITS-1:0] r_result;
    logic [MATRIX_BITS-1:0] r_decided;
    logic [BIT_W-1:0]       r_bit;
    logic [SCNT_W-1:0]      r_sample_cnt;
    logic [CNT_W-1:0]       r_rep_cnt;
    logic [CNT_W-1:0]       r_ones;
    logic [2:0]             r_avg_l;

    logic [2:0]             w_avg_clamped;
    logic [CNT_W-1:0]       w_rep;
    logic [CNT_W-1:0]       w_thresh;
    logic [CNT_W-1:0]       w_ones_total;
    logic                   w_last_rep;
    logic                   w_avg_bit;
    logic                   w_dec_bit;
    logic [MATRIX_BITS-1:0] w_msb_mask;
    logic [MATRIX_BITS-1:0] w_bit_mask;
    logic [MATRIX_BITS-1:0] w_decided_next;
    logic [MATRIX_BITS-1:0] w_next_psw;

    assign w_avg_clamped = ({29'd0, avg_control_in} > MAX_AVG_LOG2) ? 3'(MAX_AVG_LOG2)
                                                                     : avg_control_in;
    assign w_rep        = CNT_W'(1) << r_avg_l;
    // A single repetition must follow the one decision rather than a zero threshold.
    assign w_thresh     = (r_avg_l == 3'd0) ? CNT_W'(1) : (w_rep >> 1);
    assign w_ones_total = r_ones + CNT_W'(comparator_in);
    assign w_last_rep   = (r_rep_cnt == (w_rep - CNT_W'(1)));
    assign w_avg_bit    = (w_ones_total >= w_thresh);
    assign w_dec_bit    = (r_state == S_AVERAGE) ? w_avg_bit : comparator_in;

    assign w_msb_mask     = {1'b1, {(MATRIX_BITS-1){1'b0}}};
    assign w_bit_mask     = {{(MATRIX_BITS-1){1'b0}}, 1'b1} << r_bit;
    assign w_decided_next = r_decided | (w_dec_bit ? w_bit_mask : '0);
    assign w_next_psw     = w_decided_next | (w_bit_mask >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET_STATE;
            r_sample     <= RESET_SAMPLE;
            r_enable     <= 1'b0;
            r_strobe     <= 1'b0;
            r_pswitch    <= '0;
            r_nswitch    <= '0;
            r_result     <= '0;
            r_decided    <= '0;
            r_bit        <= '0;
            r_sample_cnt <= '0;
            r_rep_cnt    <= '0;
            r_ones       <= '0;
            r_avg_l      <= '0;
        end else begin
            case (r_state)
`ifdef ADC_CTRL_SINGLE_SHOT_EN
                S_IDLE: begin
                    if (start_in) begin
                        r_state      <= S_SAMPLE;
                        r_sample     <= 1'b1;
                        r_sample_cnt <= '0;
                    end
                end
`endif
                S_SAMPLE: begin
                    if (r_sample_cnt == '0) begin
                        r_avg_l <= w_avg_clamped;
                    end
                    if (r_sample_cnt == SCNT_W'(SAMPLE_CYCLES-1)) begin
                        r_state      <= S_CONVERT;
                        r_sample     <= 1'b0;
                        r_enable     <= 1'b1;
                        r_bit        <= BIT_W'(MATRIX_BITS-1);
                        r_decided    <= '0;
                        r_pswitch    <= w_msb_mask;
                        r_nswitch    <= ~w_msb_mask;
                        r_sample_cnt <= '0;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SCNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    r_decided <= w_decided_next;
                    r_pswitch <= w_next_psw;
                    r_nswitch <= ~w_next_psw;
                    r_bit     <= r_bit - BIT_W'(1);
                    if (r_bit == BIT_W'(AVG_BITS)) begin
                        r_state   <= S_AVERAGE;
                        r_rep_cnt <= '0;
                        r_ones    <= '0;
                    end
                end
                S_AVERAGE: begin
                    if (w_last_rep) begin
                        r_decided <= w_decided_next;
                        r_rep_cnt <= '0;
                        r_ones    <= '0;
                        if (r_bit == '0) begin
                            r_state   <= S_DONE;
                            r_result  <= w_decided_next;
                            r_strobe  <= 1'b1;
                            r_enable  <= 1'b0;
                            r_pswitch <= '0;
                            r_nswitch <= '0;
                        end else begin
                            r_bit     <= r_bit - BIT_W'(1);
                            r_pswitch <= w_next_psw;
                            r_nswitch <= ~w_next_psw;
                        end
                    end else begin
                        r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                        r_ones    <= w_ones_total;
                    end
                end
                S_DONE: begin
                    r_strobe  <= 1'b0;
                    r_decided <= '0;
`ifdef ADC_CTRL_SINGLE_SHOT_EN
                    r_state   <= S_IDLE;
`else
                    r_state   <= S_SAMPLE;
                    r_sample  <= 1'b1;
`endif
                end
                default: begin
                    r_state  <= RESET_STATE;
                    r_sample <= RESET_SAMPLE;
                end
            endcase
        end
    end

    assign sample_out               = r_sample;
    assign sample_out_n             = ~r_sample;
    assign enable_loop_out          = r_enable;
    assign conv_finished_strobe_out = r_strobe;
    assign pswitch_out              = r_pswitch;
    assign nswitch_out              = r_nswitch;
    assign result_out               = r_result;
    assign state_dbg_out            = r_state;

endmodule

// File: tb/tb_adc_control_param.sv
// Directed bench for adc_control_param (MATRIX_BITS=12, AVG_BITS=4, SAMPLE_CYCLES=1).
`timescale 1ns/1ps
module tb_adc_control_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        comparator_in = 1'b0;
  logic [2:0]  avg_control_in = 3'd0;
`ifdef ADC_CTRL_SINGLE_SHOT_EN
  logic        start_in = 1'b0;
`endif
  logic        sample_out;
  logic        sample_out_n;
  logic        enable_loop_out;
  logic        conv_finished_strobe_out;
  logic [11:0] pswitch_out;
  logic [11:0] nswitch_out;
  logic [11:0] result_out;
  logic [2:0]  state_dbg_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]      avg;
    logic [11:0]     conv_word;
    logic [3:0][5:0] ones;
    int              exp_result;
    int              exp_period;
  } vec_t;

  vec_t vecs[8];

  adc_control_param #(
    .MATRIX_BITS(12), .AVG_BITS(4), .MAX_AVG_LOG2(5), .SAMPLE_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .comparator_in(comparator_in),
    .avg_control_in(avg_control_in),
`ifdef ADC_CTRL_SINGLE_SHOT_EN
    .start_in(start_in),
`endif
    .sample_out(sample_out),
    .sample_out_n(sample_out_n),
    .enable_loop_out(enable_loop_out),
    .conv_finished_strobe_out(conv_finished_strobe_out),
    .pswitch_out(pswitch_out),
    .nswitch_out(nswitch_out),
    .result_out(result_out),
    .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag, input int exp_sample);
    check({tag, " sample_out"}, int'(sample_out), exp_sample);
    check({tag, " sample_out_n"}, int'(sample_out_n), 1 - exp_sample);
    check({tag, " enable"}, int'(enable_loop_out), 0);
    check({tag, " strobe"}, int'(conv_finished_strobe_out), 0);
    check({tag, " pswitch"}, int'(pswitch_out), 0);
    check({tag, " nswitch"}, int'(nswitch_out), 0);
    check({tag, " result"}, int'(result_out), 0);
  endtask

  // Called at the falling edge of the first SAMPLE cycle; returns at the
  // falling edge of the cycle after DONE. avg_b is driven from cycle 3 on.
  task automatic run_conv(input string tag, input logic [2:0] avg_a, input logic [2:0] avg_b,
                          input logic [11:0] word, input logic [3:0][5:0] ones,
                          input int exp_result, input int exp_period);
    int l, r, s, j, b, strobe_idx, strobe_cnt, psw_exp;
    l = (avg_a > 3'd5) ? 5 : int'(avg_a);
    r = 1 << l;
    strobe_idx = -1;
    strobe_cnt = 0;
    for (int i = 0; i < exp_period; i++) begin
      avg_control_in = (i < 3) ? avg_a : avg_b;
      if (i == 0) begin
        comparator_in = 1'b0;
      end else if (i <= 8) begin
        comparator_in = word[12 - i];
      end else begin
        s = (i - 9) / r;
        j = (i - 9) % r;
        b = 3 - s;
        comparator_in = 1'b0;
        if (b >= 0) comparator_in = (j < int'(ones[b]));
      end
      #1;
      if (conv_finished_strobe_out) begin
        strobe_cnt++;
        if (strobe_idx < 0) strobe_idx = i;
      end
      if (i == 0) begin
        check({tag, " sample phase sample_out"}, int'(sample_out), 1);
        check({tag, " sample phase pswitch"}, int'(pswitch_out), 0);
        check({tag, " sample phase enable"}, int'(enable_loop_out), 0);
      end
      if (i == 1) begin
        check({tag, " msb trial pswitch"}, int'(pswitch_out), 12'h800);
        check({tag, " msb trial nswitch"}, int'(nswitch_out), 12'h7ff);
        check({tag, " convert enable"}, int'(enable_loop_out), 1);
        check({tag, " convert sample_out_n"}, int'(sample_out_n), 1);
      end
      if (i == 2) begin
        psw_exp = 12'h400 | (word[11] ? 12'h800 : 12'h000);
        check({tag, " second trial pswitch"}, int'(pswitch_out), psw_exp);
      end
      if (i == exp_period - 1) begin
        check({tag, " result"}, int'(result_out), exp_result);
        check({tag, " done pswitch"}, int'(pswitch_out), 0);
        check({tag, " done enable"}, int'(enable_loop_out), 0);
      end
      @(negedge clk);
    end
    check({tag, " strobe cycle"}, strobe_idx, exp_period - 1);
    check({tag, " strobe count"}, strobe_cnt, 1);
  endtask

  initial begin
    int cnt_a, cnt_b;
    vecs[0] = '{3'd0, 12'h400, {6'd0,  6'd0,  6'd0,  6'd0},  1024, 14};
    vecs[1] = '{3'd2, 12'h000, {6'd3,  6'd2,  6'd1,  6'd0},  12,   26};
    vecs[2] = '{3'd7, 12'hfff, {6'd32, 6'd32, 6'd32, 6'd32}, 4095, 138};
    vecs[3] = '{3'd0, 12'ha5a, {6'd1,  6'd0,  6'd1,  6'd0},  2650, 14};
    vecs[4] = '{3'd1, 12'h800, {6'd1,  6'd0,  6'd2,  6'd1},  2059, 18};
    vecs[5] = '{3'd3, 12'h3c0, {6'd4,  6'd3,  6'd8,  6'd0},  970,  42};
    vecs[6] = '{3'd5, 12'h000, {6'd16, 6'd15, 6'd32, 6'd31}, 11,   138};
    vecs[7] = '{3'd6, 12'h555, {6'd0,  6'd32, 6'd17, 6'd16}, 1367, 138};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
`ifdef ADC_CTRL_SINGLE_SHOT_EN
    check_reset_outputs("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (20) begin
      #1;
      if (conv_finished_strobe_out) cnt_a++;
      if (sample_out) cnt_b++;
      @(negedge clk);
    end
    check("idle no strobe", cnt_a, 0);
    check("idle no sampling", cnt_b, 0);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    run_conv("single pulse", 3'd0, 3'd0, 12'h400, {6'd0, 6'd0, 6'd0, 6'd0}, 1024, 14);
    #1;
    check("back to idle sample_out", int'(sample_out), 0);
    start_in = 1'b1;
    @(negedge clk);
    run_conv("start held", 3'd0, 3'd0, 12'ha5a, {6'd1, 6'd0, 6'd1, 6'd0}, 2650, 14);
    start_in = 1'b0;
    #1;
    check("held start idle re-entry", int'(sample_out), 0);
    cnt_a = 0;
    repeat (10) begin
      #1;
      if (conv_finished_strobe_out) cnt_a++;
      @(negedge clk);
    end
    check("held start no extra strobe", cnt_a, 0);
`else
    check_reset_outputs("reset", 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      run_conv($sformatf("vec%0d", v), vecs[v].avg, vecs[v].avg, vecs[v].conv_word,
               vecs[v].ones, vecs[v].exp_result, vecs[v].exp_period);
    end

    // averaging request changed mid-conversion
    run_conv("avg change cur", 3'd0, 3'd3, 12'h400, {6'd0, 6'd0, 6'd0, 6'd0}, 1024, 14);
    run_conv("avg change next", 3'd3, 3'd3, 12'h3c0, {6'd4, 6'd3, 6'd8, 6'd0}, 970, 42);

    // abort at CONVERT step 5 after a nonzero result has been held
    avg_control_in = 3'd0;
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      comparator_in = (i == 2);
      #1;
      if (conv_finished_strobe_out) cnt_a++;
      @(negedge clk);
    end
    check("pre-abort result held", int'(result_out), 970);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort", 1);
    check("aborted no strobe", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("after abort", 3'd0, 3'd0, 12'h400, {6'd0, 6'd0, 6'd0, 6'd0}, 1024, 14);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
